spi_text_writer: RTL and testbench



---
 rtl/spi_text_writer_pkg.sv | 23 ++
 rtl/spi_text_writer_byte_rx.sv | 58 +++++
 rtl/spi_text_writer.sv | 162 ++++++++++++++++
 tb/tb_spi_text_writer.sv | 179 +++++++++++++++++
 4 files changed

// File: rtl/spi_text_writer_pkg.sv
// Shared constants for the SPI text writer: default geometry, ASCII control codes
// and the controller state encoding.
package spi_text_writer_pkg;

    localparam int COLS_DEF = 80;
    localparam int ROWS_DEF = 30;

    localparam logic [7:0] ASCII_SPACE = 8'h20;
    localparam logic [7:0] ASCII_BS    = 8'h08;
    localparam logic [7:0] ASCII_LF    = 8'h0A;
    localparam logic [7:0] ASCII_FF    = 8'h0C;
    localparam logic [7:0] ASCII_CR    = 8'h0D;

    typedef enum logic {
        ST_IDLE  = 1'b0,
        ST_CLEAR = 1'b1
    } state_t;

    function automatic logic is_printable(input logic [7:0] b);
        return (b >= 8'h20) && (b <= 8'h7E);
    endfunction

endpackage

// File: rtl/spi_text_writer_byte_rx.sv
// SPI mode-0 byte receiver: synchronises SCLK/MOSI/CS into clk, samples MOSI on the
// synchronised SCLK rising edge and emits one-cycle rx_valid with the assembled byte.
module spi_byte_rx (
    input  logic       i_clk,
    input  logic       i_rst,
    input  logic       i_sclk,
    input  logic       i_mosi,
    input  logic       i_cs_n,
    output logic [7:0] o_rx_byte,
    output logic       o_rx_valid
);

    logic [2:0] r_sclk;
    logic [1:0] r_mosi;
    logic [1:0] r_cs_n;
    logic [2:0] r_cnt;
    logic [6:0] r_shift;

    logic w_rise;
    logic w_cs_n;
    logic w_take;

    assign w_rise = r_sclk[1] & ~r_sclk[2];
    assign w_cs_n = r_cs_n[1];
    // The 8th edge completes its byte even if CS rises in the same cycle.
    assign w_take = w_rise & (~w_cs_n | (r_cnt == 3'd7));

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_sclk     <= '0;
            r_mosi     <= '0;
            r_cs_n     <= 2'b11;
            r_cnt      <= '0;
            r_shift    <= '0;
            o_rx_byte  <= '0;
            o_rx_valid <= 1'b0;
        end else begin
            r_sclk     <= {r_sclk[1:0], i_sclk};
            r_mosi     <= {r_mosi[0], i_mosi};
            r_cs_n     <= {r_cs_n[0], i_cs_n};
            o_rx_valid <= 1'b0;
            if (w_take) begin
                if (r_cnt == 3'd7) begin
                    o_rx_byte  <= {r_shift, r_mosi[1]};
                    o_rx_valid <= 1'b1;
                    r_cnt      <= '0;
                end else begin
                    r_shift <= {r_shift[5:0], r_mosi[1]};
                    r_cnt   <= r_cnt + 3'd1;
                end
            end else if (w_cs_n) begin
                r_cnt   <= '0;
                r_shift <= '0;
            end
        end
    end

endmodule

// File: rtl/spi_text_writer.sv
// Turns SPI-received ASCII into text-RAM writes, tracking a linear cursor and
// sweeping spaces through the buffer on form feed.
//   state    | meaning
//   ST_IDLE  | act on received bytes: print, move cursor, or start a clear
//   ST_CLEAR | write a space to every cell 0..N-1, one per cycle; bytes dropped
module spi_text_writer
    import spi_text_writer_pkg::*;
#(
    parameter int COLS   = COLS_DEF,
    parameter int ROWS   = ROWS_DEF,
    parameter int ADDR_W = 12
) (
    input  logic              i_clk,
    input  logic              i_rst,
    input  logic              i_spi_sclk,
    input  logic              i_spi_mosi,
    input  logic              i_spi_cs_n,
    output logic              o_wr_en,
    output logic [ADDR_W-1:0] o_wr_addr,
    output logic [7:0]        o_wr_data,
    output logic [ADDR_W-1:0] o_cursor,
    output logic              o_busy,
    output logic              o_overrun
);

    localparam int N = COLS * ROWS;
    localparam logic [ADDR_W-1:0] LAST     = ADDR_W'(N - 1);
    localparam logic [ADDR_W-1:0] COL_LAST = ADDR_W'(COLS - 1);
    localparam logic [ADDR_W-1:0] ROW_STEP = ADDR_W'(COLS);
    localparam logic [ADDR_W-1:0] LAST_ROW = ADDR_W'(N - COLS);
    localparam logic [ADDR_W-1:0] ONE      = ADDR_W'(1);

    logic [7:0]        w_rx_byte;
    logic              w_rx_valid;
    logic [ADDR_W-1:0] w_row_next;

    state_t            r_state;
    logic [ADDR_W-1:0] r_cursor;
    logic [ADDR_W-1:0] r_col;
    logic [ADDR_W-1:0] r_row;
    logic [ADDR_W-1:0] r_clr;
    logic              r_wr_en;
    logic [ADDR_W-1:0] r_wr_addr;
    logic [7:0]        r_wr_data;
    logic              r_busy;
    logic              r_overrun;

    spi_byte_rx u_rx (
        .i_clk      (i_clk),
        .i_rst      (i_rst),
        .i_sclk     (i_spi_sclk),
        .i_mosi     (i_spi_mosi),
        .i_cs_n     (i_spi_cs_n),
        .o_rx_byte  (w_rx_byte),
        .o_rx_valid (w_rx_valid)
    );

    // Cursor is kept as row start + column so CR/LF need no division.
    assign w_row_next = (r_row == LAST_ROW) ? '0 : r_row + ROW_STEP;

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_state   <= ST_IDLE;
            r_cursor  <= '0;
            r_col     <= '0;
            r_row     <= '0;
            r_clr     <= '0;
            r_wr_en   <= 1'b0;
            r_wr_addr <= '0;
            r_wr_data <= '0;
            r_busy    <= 1'b0;
            r_overrun <= 1'b0;
        end else begin
            r_wr_en <= 1'b0;
            case (r_state)
                ST_IDLE: begin
                    r_busy <= 1'b0;
                    if (w_rx_valid) begin
                        if (is_printable(w_rx_byte)) begin
                            r_wr_en   <= 1'b1;
                            r_wr_addr <= r_cursor;
                            r_wr_data <= w_rx_byte;
                            if (r_cursor == LAST) begin
                                r_cursor <= '0;
                                r_col    <= '0;
                                r_row    <= '0;
                            end else begin
                                r_cursor <= r_cursor + ONE;
                                if (r_col == COL_LAST) begin
                                    r_col <= '0;
                                    r_row <= w_row_next;
                                end else begin
                                    r_col <= r_col + ONE;
                                end
                            end
                        end else begin
                            case (w_rx_byte)
                                ASCII_CR: begin
                                    r_cursor <= r_row;
                                    r_col    <= '0;
                                end
                                ASCII_LF: begin
                                    r_cursor <= w_row_next;
                                    r_row    <= w_row_next;
                                    r_col    <= '0;
                                end
                                ASCII_BS: begin
                                    r_wr_en   <= 1'b1;
                                    r_wr_data <= ASCII_SPACE;
                                    if (r_cursor == '0) begin
                                        r_cursor  <= LAST;
                                        r_wr_addr <= LAST;
                                        r_col     <= COL_LAST;
                                        r_row     <= LAST_ROW;
                                    end else begin
                                        r_cursor  <= r_cursor - ONE;
                                        r_wr_addr <= r_cursor - ONE;
                                        if (r_col == '0) begin
                                            r_col <= COL_LAST;
                                            r_row <= r_row - ROW_STEP;
                                        end else begin
                                            r_col <= r_col - ONE;
                                        end
                                    end
                                end
                                ASCII_FF: begin
                                    r_state <= ST_CLEAR;
                                    r_clr   <= '0;
                                end
                                default: ;
                            endcase
                        end
                    end
                end
                ST_CLEAR: begin
                    r_wr_en   <= 1'b1;
                    r_wr_addr <= r_clr;
                    r_wr_data <= ASCII_SPACE;
                    r_busy    <= 1'b1;
                    if (w_rx_valid) r_overrun <= 1'b1;
                    if (r_clr == LAST) begin
                        r_state  <= ST_IDLE;
                        r_cursor <= '0;
                        r_col    <= '0;
                        r_row    <= '0;
                    end else begin
                        r_clr <= r_clr + ONE;
                    end
                end
                default: r_state <= ST_IDLE;
            endcase
        end
    end

    assign o_wr_en   = r_wr_en;
    assign o_wr_addr = r_wr_addr;
    assign o_wr_data = r_wr_data;
    assign o_cursor  = r_cursor;
    assign o_busy    = r_busy;
    assign o_overrun = r_overrun;

endmodule

// File: tb/tb_spi_text_writer.sv
// Bench for spi_text_writer: bit-bangs SPI bytes and scores every text-RAM write
// against a queue of expected {busy, addr, data} entries.
module tb_spi_text_writer;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        sclk = 1'b0;
    logic        mosi = 1'b0;
    logic        cs_n = 1'b1;
    logic        wr_en;
    logic [11:0] wr_addr;
    logic [7:0]  wr_data;
    logic [11:0] cursor;
    logic        busy;
    logic        overrun;

    typedef struct packed {
        logic        busy;
        logic [11:0] addr;
        logic [7:0]  data;
    } wr_t;

    int  n_vec = 0;
    int  n_err = 0;
    bit  sb_off = 1'b0;
    wr_t sb_q[$];

    always #5 clk = ~clk;

    spi_text_writer #(.COLS(80), .ROWS(30), .ADDR_W(12)) dut (
        .i_clk      (clk),
        .i_rst      (rst),
        .i_spi_sclk (sclk),
        .i_spi_mosi (mosi),
        .i_spi_cs_n (cs_n),
        .o_wr_en    (wr_en),
        .o_wr_addr  (wr_addr),
        .o_wr_data  (wr_data),
        .o_cursor   (cursor),
        .o_busy     (busy),
        .o_overrun  (overrun)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_vec++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, obs, exp, $time);
        end
    endtask

    always @(negedge clk) begin
        wr_t e;
        if (!rst && !sb_off && wr_en) begin
            if (sb_q.size() == 0) begin
                chk("unexpected_wr", 32'(wr_en), 32'd0);
            end else begin
                e = sb_q.pop_front();
                chk("wr", 32'({busy, wr_addr, wr_data}), 32'(e));
            end
        end
    end

    task automatic tick(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic spi_send(input logic [7:0] b, input int nbits = 8, input bit cs_last = 1'b0);
        cs_n = 1'b0;
        tick(4);
        for (int i = 0; i < nbits; i++) begin
            mosi = b[7-i];
            tick(4);
            sclk = 1'b1;
            if (cs_last && i == nbits - 1) cs_n = 1'b1;
            tick(4);
            sclk = 1'b0;
        end
        cs_n = 1'b1;
        mosi = 1'b0;
        tick(8);
    endtask

    task automatic send_char(input logic [7:0] b, input int addr);
        sb_q.push_back(wr_t'{busy: 1'b0, addr: 12'(addr), data: b});
        spi_send(b);
    endtask

    task automatic wait_idle(input int max_cyc);
        int k = 0;
        while (busy && k < max_cyc) begin
            tick(1);
            k++;
        end
        chk("clear_done", 32'(busy), 32'd0);
    endtask

    initial begin
        tick(3);
        chk("rst_wr_en", 32'(wr_en), 32'd0);
        chk("rst_wr_addr", 32'(wr_addr), 32'd0);
        chk("rst_wr_data", 32'(wr_data), 32'd0);
        chk("rst_cursor", 32'(cursor), 32'd0);
        chk("rst_busy", 32'(busy), 32'd0);
        chk("rst_overrun", 32'(overrun), 32'd0);
        rst = 1'b0;
        tick(2);

        send_char(8'h48, 0);
        send_char(8'h69, 1);
        chk("cursor_hi", 32'(cursor), 32'd2);

        spi_send(8'h0D);
        chk("cursor_cr0", 32'(cursor), 32'd0);
        spi_send(8'h0A);
        chk("cursor_lf80", 32'(cursor), 32'd80);
        for (int k = 0; k < 5; k++) send_char(8'h61 + 8'(k), 80 + k);
        chk("cursor_85", 32'(cursor), 32'd85);
        spi_send(8'h0D);
        chk("cursor_cr80", 32'(cursor), 32'd80);
        spi_send(8'h0A);
        chk("cursor_lf160", 32'(cursor), 32'd160);

        for (int k = 0; k < 27; k++) spi_send(8'h0A);
        chk("cursor_2320", 32'(cursor), 32'd2320);
        for (int k = 0; k < 10; k++) send_char(8'h30 + 8'(k), 2320 + k);
        chk("cursor_2330", 32'(cursor), 32'd2330);
        spi_send(8'h0A);
        chk("cursor_lf_wrap", 32'(cursor), 32'd0);

        spi_send(8'h01);
        chk("cursor_ignored", 32'(cursor), 32'd0);

        sb_q.push_back(wr_t'{busy: 1'b0, addr: 12'd2399, data: 8'h20});
        spi_send(8'h08);
        chk("cursor_bs_wrap", 32'(cursor), 32'd2399);
        send_char(8'h41, 2399);
        chk("cursor_char_wrap", 32'(cursor), 32'd0);

        for (int a = 0; a < 2400; a++)
            sb_q.push_back(wr_t'{busy: 1'b1, addr: 12'(a), data: 8'h20});
        spi_send(8'h0C);
        tick(2);
        spi_send(8'h78);
        wait_idle(5000);
        chk("overrun_set", 32'(overrun), 32'd1);
        chk("cursor_after_clear", 32'(cursor), 32'd0);
        chk("clear_all_written", 32'(sb_q.size()), 32'd0);

        spi_send(8'hC3, 5);
        send_char(8'h41, 0);
        chk("cursor_after_abort", 32'(cursor), 32'd1);

        sb_q.push_back(wr_t'{busy: 1'b0, addr: 12'd1, data: 8'h42});
        spi_send(8'h42, 8, 1'b1);
        chk("cursor_cs_coincident", 32'(cursor), 32'd2);
        chk("overrun_sticky", 32'(overrun), 32'd1);

        sb_off = 1'b1;
        spi_send(8'h0C);
        tick(20);
        chk("busy_mid_clear", 32'(busy), 32'd1);
        rst = 1'b1;
        tick(1);
        chk("rst_clear_busy", 32'(busy), 32'd0);
        chk("rst_clear_wr_en", 32'(wr_en), 32'd0);
        rst = 1'b0;
        tick(5);
        chk("post_rst_wr_en", 32'(wr_en), 32'd0);
        chk("post_rst_cursor", 32'(cursor), 32'd0);
        chk("post_rst_overrun", 32'(overrun), 32'd0);
        sb_off = 1'b0;

        chk("sb_empty", 32'(sb_q.size()), 32'd0);
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
